// File: rtl/ex_resolve_stage_pkg.sv
// Shared definitions for the EX resolve stage: branch encodings,
// exception causes and the control state enum.
package ex_resolve_stage_pkg;

    localparam int         XLEN_DEF    = 32;
    localparam logic [4:0] EXC_CODE_OV = 5'd12;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLTZ = 3'd3,
        BR_BGEZ = 3'd4,
        BR_BLEZ = 3'd5,
        BR_BGTZ = 3'd6
    } br_type_e;

    typedef enum logic {
        RUN      = 1'b0,
        EXC_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/ex_resolve_stage_if.sv
// Bundle of the EX-side, MEM-side, redirect and exception signals around
// the resolve stage. "slave" is the resolve stage, "master" its environment.
interface ex_resolve_stage_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_epoch;
    logic [XLEN-1:0] ex_pc;
    logic [2:0]      ex_br_type;
    logic [XLEN-1:0] ex_br_target;
    logic            ex_ovf_trap;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic [XLEN-1:0] alu_out;
    logic            alu_zero;
    logic            alu_less;
    logic            alu_overflow;
    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_alu_out;
    logic [4:0]      mem_rd;
    logic            mem_reg_write;
    logic [XLEN-1:0] mem_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            exc_valid;
    logic            exc_ack;
    logic [XLEN-1:0] exc_epc;
    logic            exc_bd;
    logic [4:0]      exc_code;

    modport slave (
        input  ex_valid, ex_epoch, ex_pc, ex_br_type, ex_br_target, ex_ovf_trap,
               ex_rd, ex_reg_write, alu_out, alu_zero, alu_less, alu_overflow,
               mem_ready, exc_ack,
        output ex_ready, mem_valid, mem_alu_out, mem_rd, mem_reg_write, mem_pc,
               redirect_valid, redirect_pc, exc_valid, exc_epc, exc_bd, exc_code
    );

    modport master (
        output ex_valid, ex_epoch, ex_pc, ex_br_type, ex_br_target, ex_ovf_trap,
               ex_rd, ex_reg_write, alu_out, alu_zero, alu_less, alu_overflow,
               mem_ready, exc_ack,
        input  ex_ready, mem_valid, mem_alu_out, mem_rd, mem_reg_write, mem_pc,
               redirect_valid, redirect_pc, exc_valid, exc_epc, exc_bd, exc_code
    );

endinterface

// File: rtl/ex_resolve_stage_branch_cond.sv
// Branch condition decode from the ALU Zero/Less flags. Unused encoding 7
// behaves like "no branch".
module branch_cond
    import ex_resolve_stage_pkg::*;
(
    input  logic [2:0] i_br_type,
    input  logic       i_alu_zero,
    input  logic       i_alu_less,
    output logic       o_taken
);

    // Map branch type and flags to the taken decision
    always_comb begin
        o_taken = 1'b0;
        case (i_br_type)
            BR_BEQ:  o_taken = i_alu_zero;
            BR_BNE:  o_taken = !i_alu_zero;
            BR_BLTZ: o_taken = i_alu_less;
            BR_BGEZ: o_taken = !i_alu_less;
            BR_BLEZ: o_taken = i_alu_less || i_alu_zero;
            BR_BGTZ: o_taken = !i_alu_less && !i_alu_zero;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_resolve_stage.sv
// EX resolve stage: resolves branches into a one-cycle fetch redirect,
// raises the overflow exception and forwards surviving results to MEM.
// An epoch bit squashes wrong-path instructions; the single instruction
// after a taken branch (delay slot) is always kept.
module ex_resolve_stage
    import ex_resolve_stage_pkg::*;
#(
    parameter int         XLEN   = XLEN_DEF,
    parameter logic [4:0] EXC_OV = EXC_CODE_OV
) (
    input  logic              clk,
    input  logic              rst,
    ex_resolve_stage_if.slave bus
);

    state_e          r_state;
    state_e          w_state_next;
    logic            r_cur_epoch;
    logic            r_ds_pending;
    logic [XLEN-1:0] r_ds_pc;

    logic            r_mem_valid;
    logic [XLEN-1:0] r_mem_alu_out;
    logic [4:0]      r_mem_rd;
    logic            r_mem_reg_write;
    logic [XLEN-1:0] r_mem_pc;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_exc_valid;
    logic [XLEN-1:0] r_exc_epc;
    logic            r_exc_bd;
    logic [4:0]      r_exc_code;

    logic            w_ex_ready;
    logic            w_accept;
    logic            w_live;
    logic            w_taken;
    logic            w_trap;
    logic            w_redirect;
    logic            w_ack;

    branch_cond u_branch_cond (
        .i_br_type  (bus.ex_br_type),
        .i_alu_zero (bus.alu_zero),
        .i_alu_less (bus.alu_less),
        .o_taken    (w_taken)
    );

    // ex_ready is forced low while reset is held so every output reads 0
    assign w_ex_ready = !rst && (r_state == RUN) && (!r_mem_valid || bus.mem_ready);
    assign w_accept   = bus.ex_valid && w_ex_ready;
    assign w_live     = w_accept && ((bus.ex_epoch == r_cur_epoch) || r_ds_pending);
    assign w_trap     = w_live && bus.ex_ovf_trap && bus.alu_overflow;
    assign w_redirect = w_live && w_taken && !w_trap;
    assign w_ack      = (r_state == EXC_WAIT) && bus.exc_ack && r_exc_valid;

    // Next-state logic: enter EXC_WAIT on a trap, leave on acknowledge
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:      if (w_trap) w_state_next = EXC_WAIT;
            EXC_WAIT: if (w_ack)  w_state_next = RUN;
            default:  w_state_next = RUN;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_next;
    end

    // Epoch and delay-slot tracking; a taken branch in a delay slot opens a new slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_epoch  <= 1'b0;
            r_ds_pending <= 1'b0;
            r_ds_pc      <= '0;
        end else if (w_live) begin
            if (w_redirect) begin
                r_cur_epoch  <= !r_cur_epoch;
                r_ds_pending <= 1'b1;
                r_ds_pc      <= bus.ex_pc;
            end else begin
                r_ds_pending <= 1'b0;
            end
        end else if (w_ack) begin
            r_cur_epoch  <= !r_cur_epoch;
            r_ds_pending <= 1'b0;
        end
    end

    // MEM entry: load live non-trapping results, drain when MEM takes the entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_valid     <= 1'b0;
            r_mem_alu_out   <= '0;
            r_mem_rd        <= '0;
            r_mem_reg_write <= 1'b0;
            r_mem_pc        <= '0;
        end else if (w_live && !w_trap) begin
            r_mem_valid     <= 1'b1;
            r_mem_alu_out   <= bus.alu_out;
            r_mem_rd        <= bus.ex_rd;
            r_mem_reg_write <= bus.ex_reg_write;
            r_mem_pc        <= bus.ex_pc;
        end else if (bus.mem_ready) begin
            r_mem_valid     <= 1'b0;
        end
    end

    // Redirect pulse is a plain register so it lasts exactly one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_redirect;
            if (w_redirect) r_redirect_pc <= bus.ex_br_target;
        end
    end

    // Exception request: captured on the trap, held until acknowledged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exc_valid <= 1'b0;
            r_exc_epc   <= '0;
            r_exc_bd    <= 1'b0;
            r_exc_code  <= '0;
        end else if (w_trap) begin
            r_exc_valid <= 1'b1;
            r_exc_epc   <= r_ds_pending ? r_ds_pc : bus.ex_pc;
            r_exc_bd    <= r_ds_pending;
            r_exc_code  <= EXC_OV;
        end else if (w_ack) begin
            r_exc_valid <= 1'b0;
        end
    end

    assign bus.ex_ready       = w_ex_ready;
    assign bus.mem_valid      = r_mem_valid;
    assign bus.mem_alu_out    = r_mem_alu_out;
    assign bus.mem_rd         = r_mem_rd;
    assign bus.mem_reg_write  = r_mem_reg_write;
    assign bus.mem_pc         = r_mem_pc;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.exc_valid      = r_exc_valid;
    assign bus.exc_epc        = r_exc_epc;
    assign bus.exc_bd         = r_exc_bd;
    assign bus.exc_code       = r_exc_code;

endmodule

// File: tb/tb_ex_resolve_stage.sv
// Scoreboard bench for ex_resolve_stage: directed instructions push their
// expected MEM entry / redirect / exception; a monitor pops on each output.
module tb_ex_resolve_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] pc;
    } mem_t;

    typedef struct packed {
        logic [31:0] epc;
        logic        bd;
        logic [4:0]  code;
    } exc_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   waited;
    logic exc_seen = 1'b0;

    mem_t        mem_q[$];
    logic [31:0] red_q[$];
    exc_t        exc_q[$];

    ex_resolve_stage_if #(.XLEN(32)) bus ();

    ex_resolve_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [143:0] outs;
        outs = {bus.ex_ready, bus.mem_valid, bus.mem_alu_out, bus.mem_rd, bus.mem_reg_write,
                bus.mem_pc, bus.redirect_valid, bus.redirect_pc, bus.exc_valid, bus.exc_epc,
                bus.exc_bd, bus.exc_code};
        n_vec++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL %s: outputs 0x%036h expected all zero", name, outs);
        end
    endtask

    // Drive one instruction, starting just after a rising edge; returns after its accept edge
    task automatic issue(input logic ep, input logic [31:0] pc, input logic [2:0] bt,
                         input logic [31:0] tgt, input logic trap, input logic [4:0] rd,
                         input logic rw, input logic [31:0] alu, input logic z, input logic l,
                         input logic ov, output int wcnt);
        bus.ex_valid = 1'b1; bus.ex_epoch = ep; bus.ex_pc = pc; bus.ex_br_type = bt;
        bus.ex_br_target = tgt; bus.ex_ovf_trap = trap; bus.ex_rd = rd;
        bus.ex_reg_write = rw; bus.alu_out = alu; bus.alu_zero = z; bus.alu_less = l;
        bus.alu_overflow = ov;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (bus.ex_ready) break;
            wcnt++;
            if (wcnt > 20) begin
                n_vec++; n_err++;
                $display("FAIL accept_timeout: pc 0x%08h never accepted", pc);
                break;
            end
        end
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
    endtask

    task automatic push_mem(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                            input logic [31:0] pc);
        mem_t m;
        m.alu = alu; m.rd = rd; m.rw = rw; m.pc = pc;
        mem_q.push_back(m);
    endtask

    task automatic push_exc(input logic [31:0] epc, input logic bd);
        exc_t e;
        e.epc = epc; e.bd = bd; e.code = 5'd12;
        exc_q.push_back(e);
    endtask

    task automatic ack_after(input int cycles);
        repeat (cycles) @(posedge clk);
        #1 bus.exc_ack = 1'b1;
        @(posedge clk); #1 bus.exc_ack = 1'b0;
    endtask

    // Monitor: compares every MEM handshake, redirect pulse and new exception
    initial begin : monitor
        mem_t got_m, exp_m;
        exc_t got_e, exp_e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mem_valid && bus.mem_ready) begin
                    got_m = {bus.mem_alu_out, bus.mem_rd, bus.mem_reg_write, bus.mem_pc};
                    n_vec++;
                    if (mem_q.size() == 0) begin
                        n_err++;
                        $display("FAIL mem_xfer: unexpected entry pc 0x%08h alu 0x%08h", got_m.pc, got_m.alu);
                    end else begin
                        exp_m = mem_q.pop_front();
                        if (got_m !== exp_m) begin
                            n_err++;
                            $display("FAIL mem_xfer: got alu 0x%08h rd %0d rw %0b pc 0x%08h expected alu 0x%08h rd %0d rw %0b pc 0x%08h",
                                     got_m.alu, got_m.rd, got_m.rw, got_m.pc, exp_m.alu, exp_m.rd, exp_m.rw, exp_m.pc);
                        end else
                            $display("mem   pc 0x%08h alu 0x%08h rd %0d ok", got_m.pc, got_m.alu, got_m.rd);
                    end
                end
                if (bus.redirect_valid) begin
                    n_vec++;
                    if (red_q.size() == 0) begin
                        n_err++;
                        $display("FAIL redirect: unexpected pulse pc 0x%08h", bus.redirect_pc);
                    end else if (bus.redirect_pc !== red_q[0]) begin
                        n_err++;
                        $display("FAIL redirect: got 0x%08h expected 0x%08h", bus.redirect_pc, red_q[0]);
                        void'(red_q.pop_front());
                    end else begin
                        $display("redir pc 0x%08h ok", bus.redirect_pc);
                        void'(red_q.pop_front());
                    end
                end
                if (bus.exc_valid && !exc_seen) begin
                    got_e = {bus.exc_epc, bus.exc_bd, bus.exc_code};
                    n_vec++;
                    if (exc_q.size() == 0) begin
                        n_err++;
                        $display("FAIL exception: unexpected epc 0x%08h", got_e.epc);
                    end else begin
                        exp_e = exc_q.pop_front();
                        if (got_e !== exp_e) begin
                            n_err++;
                            $display("FAIL exception: got epc 0x%08h bd %0b code %0d expected epc 0x%08h bd %0b code %0d",
                                     got_e.epc, got_e.bd, got_e.code, exp_e.epc, exp_e.bd, exp_e.code);
                        end else
                            $display("exc   epc 0x%08h bd %0b code %0d ok", got_e.epc, got_e.bd, got_e.code);
                    end
                end
                exc_seen = bus.exc_valid;
            end else begin
                exc_seen = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.ex_valid = 0; bus.ex_epoch = 0; bus.ex_pc = 0; bus.ex_br_type = 0;
        bus.ex_br_target = 0; bus.ex_ovf_trap = 0; bus.ex_rd = 0; bus.ex_reg_write = 0;
        bus.alu_out = 0; bus.alu_zero = 0; bus.alu_less = 0; bus.alu_overflow = 0;
        bus.mem_ready = 1; bus.exc_ack = 0;

        #1 rst = 1'b1;
        #2 check_all_zero("reset_initial");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Stray acknowledge with no exception pending must not toggle the epoch
        bus.exc_ack = 1'b1;
        @(posedge clk); #1 bus.exc_ack = 1'b0;

        // addu after reset
        push_mem(32'h5, 5'd3, 1'b1, 32'h0040_0000);
        issue(0, 32'h0040_0000, 3'd0, 0, 0, 5'd3, 1, 32'h5, 0, 0, 0, waited);
        // beq taken, delay slot kept, next old-epoch instruction dropped
        push_mem(32'h0, 5'd0, 1'b0, 32'h0040_0020); red_q.push_back(32'h0040_0100);
        issue(0, 32'h0040_0020, 3'd1, 32'h0040_0100, 0, 5'd0, 0, 32'h0, 1, 0, 0, waited);
        push_mem(32'h11, 5'd4, 1'b1, 32'h0040_0024);
        issue(0, 32'h0040_0024, 3'd0, 0, 0, 5'd4, 1, 32'h11, 0, 0, 0, waited);
        issue(0, 32'h0040_0028, 3'd0, 0, 0, 5'd5, 1, 32'h22, 0, 0, 0, waited);
        // bgtz taken (link-style write), then bgtz with Z=1 in its slot not taken
        push_mem(32'h0040_0108, 5'd31, 1'b1, 32'h0040_0100); red_q.push_back(32'h0040_0200);
        issue(1, 32'h0040_0100, 3'd6, 32'h0040_0200, 0, 5'd31, 1, 32'h0040_0108, 0, 0, 0, waited);
        push_mem(32'h0, 5'd0, 1'b0, 32'h0040_0104);
        issue(1, 32'h0040_0104, 3'd6, 32'h0040_0900, 0, 5'd0, 0, 32'h0, 1, 0, 0, waited);
        // addu with overflow flag: forwarded, and live in epoch 0
        push_mem(32'h7, 5'd6, 1'b1, 32'h0040_0200);
        issue(0, 32'h0040_0200, 3'd0, 0, 0, 5'd6, 1, 32'h7, 0, 0, 1, waited);

        // add overflow trap outside a delay slot
        push_exc(32'h0040_0030, 1'b0);
        issue(0, 32'h0040_0030, 3'd0, 0, 1, 5'd8, 1, 32'h8000_0000, 0, 0, 1, waited);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("exc_wait_ex_ready", {31'd0, bus.ex_ready}, 32'd0);
            check("exc_wait_no_mem", {31'd0, bus.mem_valid}, 32'd0);
            check("exc_wait_epc_held", bus.exc_epc, 32'h0040_0030);
        end
        @(posedge clk); #1 bus.exc_ack = 1'b1;
        @(posedge clk); #1 bus.exc_ack = 1'b0;
        check("ack_exc_valid", {31'd0, bus.exc_valid}, 32'd0);
        check("ack_ex_ready", {31'd0, bus.ex_ready}, 32'd1);

        // Overflow trap in the delay slot of a beq at 0x0040_0040 (epoch now 1)
        push_mem(32'h0, 5'd0, 1'b0, 32'h0040_0040); red_q.push_back(32'h0040_0300);
        issue(1, 32'h0040_0040, 3'd1, 32'h0040_0300, 0, 5'd0, 0, 32'h0, 1, 0, 0, waited);
        push_exc(32'h0040_0040, 1'b1);
        issue(1, 32'h0040_0044, 3'd0, 0, 1, 5'd9, 1, 32'h7fff_ffff, 0, 0, 1, waited);
        ack_after(2);

        // MEM back-pressure for 3 cycles, then back-to-back transfers
        bus.mem_ready = 1'b0;
        push_mem(32'hAA, 5'd7, 1'b1, 32'h0040_0400);
        issue(1, 32'h0040_0400, 3'd0, 0, 0, 5'd7, 1, 32'hAA, 0, 0, 0, waited);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ex_ready", {31'd0, bus.ex_ready}, 32'd0);
            check("stall_mem_alu", bus.mem_alu_out, 32'hAA);
            check("stall_mem_rd", {27'd0, bus.mem_rd}, 32'd7);
        end
        @(posedge clk); #1 bus.mem_ready = 1'b1;
        push_mem(32'hBB, 5'd8, 1'b1, 32'h0040_0404);
        issue(1, 32'h0040_0404, 3'd0, 0, 0, 5'd8, 1, 32'hBB, 0, 0, 0, waited);
        check("b2b_first_wait", waited, 0);
        push_mem(32'hCC, 5'd9, 1'b1, 32'h0040_0408);
        issue(1, 32'h0040_0408, 3'd0, 0, 0, 5'd9, 1, 32'hCC, 0, 0, 0, waited);
        check("b2b_second_wait", waited, 0);

        // bltz taken, then bne taken inside its delay slot opens a fresh slot
        push_mem(32'h0, 5'd0, 1'b0, 32'h0040_0410); red_q.push_back(32'h0040_0500);
        issue(1, 32'h0040_0410, 3'd3, 32'h0040_0500, 0, 5'd0, 0, 32'h0, 0, 1, 0, waited);
        push_mem(32'h0, 5'd0, 1'b0, 32'h0040_0414); red_q.push_back(32'h0040_0600);
        issue(1, 32'h0040_0414, 3'd2, 32'h0040_0600, 0, 5'd0, 0, 32'h0, 0, 0, 0, waited);
        push_mem(32'h33, 5'd10, 1'b1, 32'h0040_0418);
        issue(0, 32'h0040_0418, 3'd0, 0, 0, 5'd10, 1, 32'h33, 0, 0, 0, waited);
        issue(0, 32'h0040_041C, 3'd0, 0, 0, 5'd10, 1, 32'h34, 0, 0, 0, waited);
        push_mem(32'h44, 5'd11, 1'b1, 32'h0040_0600);
        issue(1, 32'h0040_0600, 3'd0, 0, 0, 5'd11, 1, 32'h44, 0, 0, 0, waited);

        // Asynchronous reset during a MEM stall discards the held entry
        @(negedge clk); @(posedge clk); #1 bus.mem_ready = 1'b0;
        issue(1, 32'h0040_0500, 3'd0, 0, 0, 5'd10, 1, 32'h55, 0, 0, 0, waited);
        #2 rst = 1'b1;
        #1 check_all_zero("reset_mid_stall");
        @(posedge clk); #1 rst = 1'b0; bus.mem_ready = 1'b1;
        push_mem(32'h5, 5'd3, 1'b1, 32'h0040_0600);
        issue(0, 32'h0040_0600, 3'd0, 0, 0, 5'd3, 1, 32'h5, 0, 0, 0, waited);

        // Asynchronous reset during EXC_WAIT discards the exception
        push_exc(32'h0040_0700, 1'b0);
        issue(0, 32'h0040_0700, 3'd0, 0, 1, 5'd3, 1, 32'h0, 0, 0, 1, waited);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("reset_mid_exc_wait");
        @(posedge clk); #1 rst = 1'b0;
        push_mem(32'h66, 5'd12, 1'b1, 32'h0040_0704);
        issue(0, 32'h0040_0704, 3'd0, 0, 0, 5'd12, 1, 32'h66, 0, 0, 0, waited);

        repeat (5) @(negedge clk);
        check("mem_queue_drained", mem_q.size(), 0);
        check("redirect_queue_drained", red_q.size(), 0);
        check("exc_queue_drained", exc_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_resolve_stage.md
Name: ex_resolve_stage

Overview:
- Consumer end of the ALU result/flag interface, placed between the EX stage and the EX/MEM boundary of the pipeline.
- Takes ALU_out and the Zero/Less/Overflow flags for each issued instruction and does three jobs:
  - resolves conditional branches and emits the fetch redirect;
  - raises the arithmetic-overflow exception;
  - registers surviving results into the MEM stage behind a valid/ready handshake.
- Tracks a branch/exception epoch so that wrong-path instructions are squashed, with MIPS delay-slot semantics.

Parameters:
- XLEN, 32, datapath and PC width.
- EXC_OV, 5'd12, exception code reported for arithmetic overflow.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  EX-stage instruction present.
- ex_ready  out  1  block accepts EX instruction this cycle.
- ex_epoch  in  1  epoch tag attached by fetch.
- ex_pc  in  XLEN  PC of EX instruction.
- ex_br_type  in  3  0 none, 1 beq, 2 bne, 3 bltz, 4 bgez, 5 blez, 6 bgtz; 7 is treated as none.
- ex_br_target  in  XLEN  branch target.
- ex_ovf_trap  in  1  instruction traps on overflow (add/addi/sub).
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  writes register file.
- alu_out  in  XLEN  ALU result.
- alu_zero  in  1  ALU Zero flag.
- alu_less  in  1  ALU Less flag.
- alu_overflow  in  1  ALU Overflow flag.
- mem_valid  out  1  MEM-stage entry valid.
- mem_ready  in  1  MEM stage accepts.
- mem_alu_out  out  XLEN  registered ALU result.
- mem_rd  out  5  registered destination register.
- mem_reg_write  out  1  registered write enable.
- mem_pc  out  XLEN  registered PC.
- redirect_valid  out  1  one-cycle pulse.
- redirect_pc  out  XLEN  fetch target.
- exc_valid  out  1  exception request, held until acknowledged.
- exc_ack  in  1  exception handler accepted.
- exc_epc  out  XLEN  exception PC.
- exc_bd  out  1  faulting instruction is in a delay slot.
- exc_code  out  5  exception cause.

Behaviour:
- Reset: all outputs 0. Internal state: state=RUN, cur_epoch=0, ds_pending=0, ds_pc=0.
- States: RUN, EXC_WAIT.
- ex_ready = (state==RUN) && (!mem_valid || mem_ready).
- Accept = ex_valid && ex_ready. Nothing happens without an accept.
- An accepted instruction is "live" if either:
  - ex_epoch==cur_epoch, or
  - ds_pending==1. This is the delay slot; it is live regardless of epoch.
- A non-live accepted instruction is consumed and dropped, with no side effects.
- Branch taken decode (live instruction):
  - beq: Z
  - bne: !Z
  - bltz: L
  - bgez: !L
  - blez: L|Z
  - bgtz: !L&!Z
- Live, taken branch: next cycle redirect_valid=1 and redirect_pc=ex_br_target. Same edge: cur_epoch toggles, ds_pending←1, ds_pc←ex_pc.
- Branch entries still go to MEM with reg_write as supplied, to support link variants.
- Delay-slot accept clears ds_pending.
- Live, ex_ovf_trap && alu_overflow:
  - Nothing is written to MEM for that instruction.
  - Next cycle: exc_valid=1, exc_code=EXC_OV, state←EXC_WAIT.
  - If it is the delay slot: exc_epc=ds_pc and exc_bd=1. Otherwise: exc_epc=ex_pc and exc_bd=0.
- EXC_WAIT:
  - ex_ready=0.
  - exc_valid and the exception fields are held stable until exc_ack.
  - On exc_ack: exc_valid←0, cur_epoch toggles, ds_pending←0, state←RUN.
  - exc_ack while exc_valid=0 is ignored.
- Overflow on an instruction with ex_ovf_trap=0 (addu/subu): no exception, result forwarded normally.
- Other live instructions:
  - mem_* are loaded on the accept edge and mem_valid←1.
  - The MEM entry holds stable while mem_valid && !mem_ready.
  - If mem_ready and there is no accept, mem_valid←0.
- Latency: one cycle from EX accept to mem_valid, redirect_valid, or exc_valid.
- Throughput: one instruction per cycle when mem_ready=1.
- redirect_valid is exactly one cycle per taken branch, even if MEM back-pressure begins the next cycle.
- Taken branch in a delay slot: the redirect is generated and ds_pending stays 1 for the new slot; ds_pc is updated.
- Asynchronous rst mid-EXC_WAIT or mid-stall: everything returns immediately to reset values, and the pending exception is discarded.

Decomposition:
- Shared pipeline package:
  - branch-type encodings (BR_NONE..BR_BGTZ);
  - exception codes (EXC_OV);
  - state enum RUN/EXC_WAIT.
- One sub-module is natural: branch_cond (purely combinational): inputs ex_br_type, alu_zero, alu_less; output taken.

Test Plan:
- Reset: assert rst mid-stream → all outputs 0 asynchronously. After release, an addu of alu_out=0x0000_0005, rd=3 gives mem_valid=1, mem_alu_out=5, mem_rd=3 one cycle later.
- beq with alu_zero=1, target 0x0040_0100, pc 0x0040_0020 → redirect_valid pulses once with redirect_pc=0x0040_0100. Next old-epoch instruction (delay slot) reaches MEM. Following old-epoch instruction is dropped (no mem_valid).
- bgtz with alu_less=0, alu_zero=0 → taken. Same op with alu_zero=1 → no redirect, epoch unchanged.
- add with ex_ovf_trap=1, alu_overflow=1, pc 0x0040_0030:
  - exc_valid=1, exc_epc=0x0040_0030, exc_code=12, exc_bd=0;
  - ex_ready=0 and no MEM write;
  - exc_ack after 4 cycles → exc_valid falls next edge and ex_ready returns.
- Overflow add in the delay slot of branch pc 0x0040_0040 → exc_epc=0x0040_0040, exc_bd=1.
- mem_ready=0 for 3 cycles with a full MEM entry → ex_ready=0 and mem_* stable. mem_ready=1 with ex_valid=1 → back-to-back transfer with no bubble.
